// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: trial-subtract the divisor from the
// shifted partial remainder and keep the difference when it does not borrow.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // partial < 2*divisor, so the top bit of diff is exactly the borrow
    always_comb begin
        diff     = partial - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        next_rem = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define SEQ_DIVIDER_SIGNED_EN to honour SIGNED as two's-complement division.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_ZERO
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] mag_a, mag_b, q_next, step_rem;
    logic [CW-1:0]    cnt;
    logic             zero, neg_q, neg_r, sgn, last, q_bit;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign sgn = SIGNED;
`else
    logic unused_signed;
    assign unused_signed = SIGNED;
    assign sgn           = 1'b0;
`endif

    assign mag_a  = (sgn && DIVIDEND[WIDTH-1]) ? -DIVIDEND : DIVIDEND;
    assign mag_b  = (sgn && DIVISOR[WIDTH-1])  ? -DIVISOR  : DIVISOR;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign q_next = {quo[WIDTH-2:0], q_bit};

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial  ({rem, quo[WIDTH-1]}),
        .divisor  (dvs),
        .next_rem (step_rem),
        .q_bit    (q_bit)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            S_IDLE: if (START) state_next = S_BUSY;
            S_BUSY: begin
                BUSY = 1'b1;
                if (zero || last) state_next = S_DONE;
            end
            S_DONE: begin
                BUSY       = 1'b1;
                DONE       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            zero      <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            QUOTIENT  <= '0;
            REMAINDER <= '0;
            DIV_ZERO  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (START) begin
                    // on a zero divisor quo carries the raw dividend to the result
                    zero  <= (DIVISOR == '0);
                    quo   <= (DIVISOR == '0) ? DIVIDEND : mag_a;
                    dvs   <= mag_b;
                    rem   <= '0;
                    cnt   <= '0;
                    neg_q <= sgn & (DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1]);
                    neg_r <= sgn & DIVIDEND[WIDTH-1];
                end
                S_BUSY: begin
                    if (zero) begin
                        QUOTIENT  <= '1;
                        REMAINDER <= quo;
                        DIV_ZERO  <= 1'b1;
                    end else begin
                        rem <= step_rem;
                        quo <= q_next;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            QUOTIENT  <= neg_q ? -q_next : q_next;
                            REMAINDER <= neg_r ? -step_rem : step_rem;
                            DIV_ZERO  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued at issue time
// and popped when DONE is observed.
module tb_seq_divider;

    logic        CLK = 1'b0;
    logic        RESET, START, SIGNED;
    logic [31:0] DIVIDEND, DIVISOR, QUOTIENT, REMAINDER;
    logic        BUSY, DONE, DIV_ZERO;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    seq_divider #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SIGNED    (SIGNED),
        .DIVIDEND  (DIVIDEND),
        .DIVISOR   (DIVISOR),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .QUOTIENT  (QUOTIENT),
        .REMAINDER (REMAINDER),
        .DIV_ZERO  (DIV_ZERO)
    );

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        int   sa, sd;
        if (b == 32'd0) begin
            e = '{q: 32'hFFFF_FFFF, r: a, dz: 1'b1, lat: 2};
            return e;
        end
        e = '{q: a / b, r: a % b, dz: 1'b0, lat: 33};
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (s) begin
            sa = a;
            sd = b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else begin
                e.q = sa / sd;
                e.r = sa % sd;
            end
        end
`else
        sa = 0;
        sd = int'(s);
`endif
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge CLK);
        DIVIDEND = a;
        DIVISOR  = b;
        SIGNED   = s;
        START    = 1'b1;
    endtask

    // Waits (bounded) for DONE; lat counts edges starting with the sampling edge.
    task automatic collect(output int lat, output logic busy_ok, output logic pulse_ok);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (lat == 1) START = 1'b0;
            if (!BUSY) busy_ok = 1'b0;
        end while (!DONE && lat < 60);
        @(posedge CLK);
        @(negedge CLK);
        pulse_ok = !DONE && !BUSY;
    endtask

    task automatic test_reset;
        RESET    = 1'b0;
        START    = 1'b0;
        SIGNED   = 1'b0;
        DIVIDEND = 32'd0;
        DIVISOR  = 32'd0;
        repeat (2) @(negedge CLK);
        vectors++;
        if ({BUSY, DONE, QUOTIENT, REMAINDER, DIV_ZERO} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dz=%b, want all zero",
                     BUSY, DONE, QUOTIENT, REMAINDER, DIV_ZERO);
        end
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_unsigned;
        logic [31:0] av[7];
        logic [31:0] bv[7];
        int          lat;
        logic        busy_ok, pulse_ok;
        exp_t        e;
        av = '{32'd100, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, $urandom, $urandom};
        bv = '{32'd7, 32'd5, 32'd7, 32'hFFFF_FFFF, 32'd3, $urandom_range(1, 1000), $urandom | 32'd1};
        for (int i = 0; i < 7; i++) begin
            if (i == 0) exp_q.push_back('{q: 32'd14, r: 32'd2, dz: 1'b0, lat: 33});
            else        exp_q.push_back(model(av[i], bv[i], 1'b0));
            issue(av[i], bv[i], 1'b0);
            collect(lat, busy_ok, pulse_ok);
            e = exp_q.pop_front();
            vectors++;
            if ({lat, busy_ok, pulse_ok} !== {e.lat, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL unsigned_timing[%0d]: lat=%0d busy_ok=%b pulse_ok=%b, want lat=%0d 1 1",
                         i, lat, busy_ok, pulse_ok, e.lat);
            end
            vectors++;
            if ({QUOTIENT, REMAINDER, DIV_ZERO} !== {e.q, e.r, e.dz}) begin
                miscompares++;
                $display("FAIL unsigned_result[%0d] %h/%h: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         i, av[i], bv[i], QUOTIENT, REMAINDER, DIV_ZERO, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_div_zero;
        int   lat;
        logic busy_ok, pulse_ok;
        exp_t e;
        exp_q.push_back('{q: 32'hFFFF_FFFF, r: 32'h1234_5678, dz: 1'b1, lat: 2});
        issue(32'h1234_5678, 32'd0, 1'b0);
        collect(lat, busy_ok, pulse_ok);
        e = exp_q.pop_front();
        vectors++;
        if ({lat, busy_ok, pulse_ok} !== {e.lat, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL div_zero_timing: lat=%0d busy_ok=%b pulse_ok=%b, want lat=%0d 1 1",
                     lat, busy_ok, pulse_ok, e.lat);
        end
        repeat (5) @(negedge CLK);
        vectors++;
        if ({QUOTIENT, REMAINDER, DIV_ZERO} !== {e.q, e.r, e.dz}) begin
            miscompares++;
            $display("FAIL div_zero_hold: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     QUOTIENT, REMAINDER, DIV_ZERO, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_back_to_back;
        int   lat, dones, first_lat;
        exp_t e;
        exp_q.push_back('{q: 32'hFFFF_FFFF, r: 32'd0, dz: 1'b0, lat: 33});
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        dones     = 0;
        first_lat = 0;
        for (lat = 1; lat <= 45; lat++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (lat == 1) START = 1'b0;
            if (lat == 9) begin
                DIVIDEND = 32'd50;
                DIVISOR  = 32'd5;
                START    = 1'b1;
            end
            if (lat == 10) START = 1'b0;
            if (DONE) begin
                dones++;
                if (first_lat == 0) first_lat = lat;
            end
        end
        e = exp_q.pop_front();
        vectors++;
        if (dones !== 1 || first_lat !== e.lat) begin
            miscompares++;
            $display("FAIL ignore_start_timing: dones=%0d first_done=%0d, want 1 at %0d",
                     dones, first_lat, e.lat);
        end
        vectors++;
        if ({QUOTIENT, REMAINDER, DIV_ZERO} !== {e.q, e.r, e.dz}) begin
            miscompares++;
            $display("FAIL ignore_start_result: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                     QUOTIENT, REMAINDER, DIV_ZERO, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_reset_mid;
        int   lat, dones;
        logic busy_ok, pulse_ok;
        exp_t e;
        issue(32'd1000, 32'd3, 1'b0);
        repeat (15) @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        RESET = 1'b0;
        #1;
        vectors++;
        if ({BUSY, DONE, QUOTIENT, REMAINDER, DIV_ZERO} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b q=%h r=%h dz=%b, want all zero",
                     BUSY, DONE, QUOTIENT, REMAINDER, DIV_ZERO);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (i == 2) RESET = 1'b1;
            if (DONE) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: dones=%0d, want 0", dones);
        end
        exp_q.push_back('{q: 32'd2, r: 32'd1, dz: 1'b0, lat: 33});
        issue(32'd9, 32'd4, 1'b0);
        collect(lat, busy_ok, pulse_ok);
        e = exp_q.pop_front();
        vectors++;
        if ({lat, QUOTIENT, REMAINDER, DIV_ZERO} !== {e.lat, e.q, e.r, e.dz}) begin
            miscompares++;
            $display("FAIL reset_mid_fresh: lat=%0d q=%h r=%h dz=%b, want lat=%0d q=%h r=%h dz=%b",
                     lat, QUOTIENT, REMAINDER, DIV_ZERO, e.lat, e.q, e.r, e.dz);
        end
    endtask

    task automatic test_signed_mode;
        logic [31:0] av[5];
        logic [31:0] bv[5];
        int          lat;
        logic        busy_ok, pulse_ok;
        exp_t        e;
        av = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF8, $urandom};
        bv = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, $urandom | 32'd1};
        for (int i = 0; i < 5; i++) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (i == 0)      exp_q.push_back('{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0, lat: 33});
            else if (i == 1) exp_q.push_back('{q: 32'h8000_0000, r: 32'd0, dz: 1'b0, lat: 33});
            else             exp_q.push_back(model(av[i], bv[i], 1'b1));
`else
            if (i == 0)      exp_q.push_back('{q: 32'h7FFF_FFFC, r: 32'd1, dz: 1'b0, lat: 33});
            else             exp_q.push_back(model(av[i], bv[i], 1'b0));
`endif
            issue(av[i], bv[i], 1'b1);
            collect(lat, busy_ok, pulse_ok);
            e = exp_q.pop_front();
            vectors++;
            if ({lat, QUOTIENT, REMAINDER, DIV_ZERO} !== {e.lat, e.q, e.r, e.dz}) begin
                miscompares++;
                $display("FAIL signed_sel[%0d] %h/%h: lat=%0d q=%h r=%h dz=%b, want lat=%0d q=%h r=%h dz=%b",
                         i, av[i], bv[i], lat, QUOTIENT, REMAINDER, DIV_ZERO, e.lat, e.q, e.r, e.dz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_div_zero();
        test_unsigned();
        test_back_to_back();
        test_reset_mid();
        test_signed_mode();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
